// File: rtl/barrel_pkg.sv
// Shared definitions for the barrel rotator scheduler: default widths,
// FSM state encoding and requester ID constants.
package barrel_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int SEL_W_DEF  = 3;
    localparam int CNT_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ROT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/barrel2.sv
// Registered left rotator: each clock edge rotates either the freshly loaded
// word or the current output by Select bit positions.
module barrel2 #(
    parameter int data_size = 8,
    localparam int SW = $clog2(data_size)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Load,
    input  logic [SW-1:0]        Select,
    input  logic [data_size-1:0] Data_in,
    output logic [data_size-1:0] Data_out
);

    localparam logic [SW:0] FULL = (SW+1)'(data_size);

    logic [data_size-1:0] src;
    logic [SW:0]          back;

    // Pick the rotate source and the complementary shift for the wrapped bits.
    always_comb begin
        src  = Load ? Data_in : Data_out;
        back = FULL - {1'b0, Select};
    end

    // Rotate once per clock; a zero Select leaves the word unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Data_out <= '0;
        end else begin
            Data_out <= (src << Select) | (src >> back);
        end
    end

endmodule

// File: rtl/barrel_rot_sched.sv
// Round-robin scheduler sharing one barrel2 rotator between two requesters.
// A command rotates its word by sel once per pass, cnt passes in total, and
// the result is returned with the issuing requester's ID.
module barrel_rot_sched
    import barrel_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic [CNT_W-1:0]  req0_cnt,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [SEL_W-1:0]  req1_sel,
    input  logic [CNT_W-1:0]  req1_cnt,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_id,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    logic              rr_ptr;
    logic [DATA_W-1:0] cap_data;
    logic [SEL_W-1:0]  cap_sel;
    logic [CNT_W-1:0]  cap_cnt;
    logic [CNT_W-1:0]  remaining;

    logic              grant_any;
    logic              grant_id;
    logic              brl_load;
    logic [SEL_W-1:0]  brl_sel;
    logic [DATA_W-1:0] brl_out;

    // Arbitration: only in IDLE and out of reset; rr_ptr breaks ties.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = REQ_ID0;
        if (state == IDLE && reset_n) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_id  = rr_ptr;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = REQ_ID0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = REQ_ID1;
            end
        end
    end

    assign req0_ready = grant_any && (grant_id == REQ_ID0);
    assign req1_ready = grant_any && (grant_id == REQ_ID1);

    // Rotator controls: load on the first pass, keep rotating in ROT, hold otherwise.
    always_comb begin
        brl_load = 1'b0;
        brl_sel  = '0;
        case (state)
            LOAD: begin
                brl_load = 1'b1;
                brl_sel  = (cap_cnt == '0) ? '0 : cap_sel;
            end
            ROT:     brl_sel = cap_sel;
            default: brl_sel = '0;
        endcase
    end

    barrel2 #(.data_size(DATA_W)) u_brl (
        .clk      (clk),
        .reset    (~reset_n),
        .Load     (brl_load),
        .Select   (brl_sel),
        .Data_in  (cap_data),
        .Data_out (brl_out)
    );

    assign res_data = brl_out;

    // Command FSM: capture, count passes, present the result until it is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            cap_data  <= '0;
            cap_sel   <= '0;
            cap_cnt   <= '0;
            remaining <= '0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cap_data <= grant_id ? req1_data : req0_data;
                        cap_sel  <= grant_id ? req1_sel  : req0_sel;
                        cap_cnt  <= grant_id ? req1_cnt  : req0_cnt;
                        res_id   <= grant_id;
                        rr_ptr   <= ~grant_id;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    remaining <= cap_cnt - CNT_ONE;
                    if (cap_cnt == '0 || cap_cnt == CNT_ONE) begin
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state     <= ROT;
                    end
                end
                ROT: begin
                    remaining <= remaining - CNT_ONE;
                    if (remaining == CNT_ONE) begin
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_rot_sched.sv
// Testbench for barrel_rot_sched: table of directed commands, hand-written
// reset / arbitration / back-pressure sequences and randomized traffic
// checked against an arithmetic model of the rotate and round-robin rules.
module tb_barrel_rot_sched;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 4;

    typedef struct {
        int req;
        int data;
        int sel;
        int cnt;
        int exp_data;
        int exp_lat;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req0_valid = 1'b0;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_data = '0;
    logic [SEL_W-1:0]  req0_sel = '0;
    logic [CNT_W-1:0]  req0_cnt = '0;
    logic              req1_valid = 1'b0;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_data = '0;
    logic [SEL_W-1:0]  req1_sel = '0;
    logic [CNT_W-1:0]  req1_cnt = '0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [DATA_W-1:0] res_data;
    logic              res_id;
    logic              busy;

    int total = 0;
    int bad = 0;
    int cycle_count = 0;
    bit model_rr = 1'b0;

    barrel_rot_sched #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_sel   (req0_sel),
        .req0_cnt   (req0_cnt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_sel   (req1_sel),
        .req1_cnt   (req1_cnt),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure result latency.
    always @(posedge clk) cycle_count <= cycle_count + 1;

    // Reference: rotate left by the total distance sel*cnt, wrapped to the word.
    function automatic int model_rot(input int data, input int sel, input int cnt);
        int amt;
        int mask;
        mask = (1 << DATA_W) - 1;
        amt  = (sel * cnt) % DATA_W;
        return ((data << amt) | ((data & mask) >> (DATA_W - amt))) & mask;
    endfunction

    function automatic int model_lat(input int cnt);
        return ((cnt == 0) ? 1 : cnt) + 1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: timed out at t=%0t", name, $time);
    endtask

    task automatic drive_req(input int r, input bit v, input vec_t c);
        if (r == 0) begin
            req0_valid = v;
            req0_data  = DATA_W'(c.data);
            req0_sel   = SEL_W'(c.sel);
            req0_cnt   = CNT_W'(c.cnt);
        end else begin
            req1_valid = v;
            req1_data  = DATA_W'(c.data);
            req1_sel   = SEL_W'(c.sel);
            req1_cnt   = CNT_W'(c.cnt);
        end
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (res_valid) got = 1'b1;
        end
    endtask

    task automatic wait_result(input int exp_data, input int exp_id, input int exp_lat,
                               input int acc, input int stall);
        bit got;
        res_ready = (stall == 0);
        wait_valid(got);
        if (!got) begin
            fail_now("result_wait");
            res_ready = 1'b1;
            return;
        end
        checkOutput("res_data", int'(res_data), exp_data);
        checkOutput("res_id", int'(res_id), exp_id);
        checkOutput("latency", cycle_count - acc, exp_lat);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("stall_valid", int'(res_valid), 1);
            checkOutput("stall_data", int'(res_data), exp_data);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Present up to two commands at once and serve them in model arbitration order.
    task automatic applyStimulus(input bit v0, input bit v1, input vec_t c0, input vec_t c1,
                                 input int stall);
        vec_t c[2];
        bit   pend[2];
        int   exp_id;
        int   got_id;
        int   acc;
        bit   got;
        c[0] = c0;
        c[1] = c1;
        pend[0] = v0;
        pend[1] = v1;
        drive_req(0, v0, c0);
        drive_req(1, v1, c1);
        for (int k = 0; k < 2 && (pend[0] || pend[1]); k++) begin
            exp_id = (pend[0] && pend[1]) ? int'(model_rr) : (pend[0] ? 0 : 1);
            got = 1'b0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) got = 1'b1;
            end
            if (!got) begin
                fail_now("grant_wait");
                break;
            end
            got_id = req1_ready ? 1 : 0;
            checkOutput("grant_id", got_id, exp_id);
            checkOutput("ready_onehot", int'(req0_ready && req1_ready), 0);
            acc = cycle_count;
            @(posedge clk);
            #1;
            pend[got_id] = 1'b0;
            drive_req(got_id, 1'b0, c[got_id]);
            model_rr = (got_id == 0);
            wait_result(c[got_id].exp_data, got_id, c[got_id].exp_lat, acc, stall);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Hang guard in case a bounded wait is somehow bypassed.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        vec_t table_v[8];
        vec_t v;
        vec_t w;
        bit   got;
        bit   saw;
        int   hold_data;
        int   hold_id;

        table_v[0] = '{0, 'h81, 1,  3, 'h0C,  4};
        table_v[1] = '{1, 'h3C, 5,  0, 'h3C,  2};
        table_v[2] = '{0, 'h01, 7,  1, 'h80,  2};
        table_v[3] = '{1, 'hA5, 4,  2, 'hA5,  3};
        table_v[4] = '{0, 'h96, 3, 15, 'hD2, 16};
        table_v[5] = '{1, 'h5A, 0,  7, 'h5A,  8};
        table_v[6] = '{0, 'h12, 6,  3, 'h48,  4};
        table_v[7] = '{1, 'hC3, 2,  4, 'hC3,  5};

        // Reset state, with a request pending to show ready stays low.
        req0_valid = 1'b1;
        #12;
        checkOutput("rst_res_valid", int'(res_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_req0_ready", int'(req0_ready), 0);
        checkOutput("rst_res_data", int'(res_data), 0);
        checkOutput("rst_res_id", int'(res_id), 0);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed single-requester commands.
        for (int i = 0; i < 8; i++) begin
            if (table_v[i].req == 0) applyStimulus(1'b1, 1'b0, table_v[i], table_v[i], 0);
            else                     applyStimulus(1'b0, 1'b1, table_v[i], table_v[i], 0);
        end

        // Reset asserted mid-rotation of a 10-pass command.
        v = '{0, 'h5A, 3, 10, 0, 0};
        drive_req(0, 1'b1, v);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req0_ready) got = 1'b1;
        end
        if (!got) fail_now("rot_reset_grant");
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        req0_valid = 1'b1;
        reset_n = 1'b0;
        #2;
        checkOutput("midrst_res_valid", int'(res_valid), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_req0_ready", int'(req0_ready), 0);
        checkOutput("midrst_res_data", int'(res_data), 0);
        checkOutput("midrst_brl_out", int'(dut.u_brl.Data_out), 0);
        req0_valid = 1'b0;
        model_rr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) saw = 1'b1;
        end
        checkOutput("midrst_no_result", int'(saw), 0);
        checkOutput("midrst_idle", int'(busy), 0);
        @(posedge clk);
        #1;
        v = '{0, 'hF0, 1, 2, 'hC3, 3};
        applyStimulus(1'b1, 1'b0, v, v, 0);

        // Both requesters at once: req0 then req1; after a lone req0, req1 wins the tie.
        v = '{0, 'hA5, 4, 2, 'hA5, 3};
        w = '{1, 'h01, 7, 1, 'h80, 2};
        applyStimulus(1'b1, 1'b1, v, w, 0);
        applyStimulus(1'b1, 1'b0, '{0, 'h33, 1, 1, 'h66, 2}, w, 0);
        applyStimulus(1'b1, 1'b1, v, w, 0);

        // Consumer stalls five cycles in DONE while req1 waits.
        v = '{0, 'h81, 1, 3, 'h0C, 4};
        w = '{1, 'h11, 1, 1, 'h22, 2};
        res_ready = 1'b0;
        drive_req(0, 1'b1, v);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req0_ready) got = 1'b1;
        end
        if (!got) fail_now("stall_grant");
        model_rr = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        drive_req(1, 1'b1, w);
        wait_valid(got);
        if (!got) begin
            fail_now("stall_result");
        end else begin
            hold_data = int'(res_data);
            hold_id   = int'(res_id);
            checkOutput("stall_first_data", hold_data, 'h0C);
            checkOutput("stall_first_id", hold_id, 0);
            for (int s = 0; s < 5; s++) begin
                @(negedge clk);
                checkOutput("stall_hold_valid", int'(res_valid), 1);
                checkOutput("stall_hold_data", int'(res_data), hold_data);
                checkOutput("stall_hold_id", int'(res_id), hold_id);
                checkOutput("stall_busy", int'(busy), 1);
                checkOutput("stall_no_ready", int'(req0_ready || req1_ready), 0);
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(negedge clk);
        checkOutput("stall_after_idle", int'(busy), 0);
        checkOutput("stall_after_valid", int'(res_valid), 0);
        @(posedge clk);
        #1;

        // Randomized traffic against the arithmetic model.
        for (int n = 0; n < 30; n++) begin
            int pat;
            pat = int'($urandom_range(0, 2));
            v.req = 0;
            v.data = int'($urandom_range(0, 255));
            v.sel  = int'($urandom_range(0, 7));
            v.cnt  = int'($urandom_range(0, 15));
            v.exp_data = model_rot(v.data, v.sel, v.cnt);
            v.exp_lat  = model_lat(v.cnt);
            w.req = 1;
            w.data = int'($urandom_range(0, 255));
            w.sel  = int'($urandom_range(0, 7));
            w.cnt  = int'($urandom_range(0, 15));
            w.exp_data = model_rot(w.data, w.sel, w.cnt);
            w.exp_lat  = model_lat(w.cnt);
            applyStimulus(pat != 1, pat != 0, v, w, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
